frame_tick_rx: RTL and testbench

Receives the slow, free-running frame clock (the ~60 Hz square wave from the frame clock divider, or VGA vsync) into the 100 MHz system domain. Synchronises it, emits one single-cycle frame strobe per rising edge, measures the period between edges, and tracks lock and loss. Game-logic and sprite-update blocks use it as their frame-rate time base.

---
 rtl/frame_tick_rx.sv | 182 ++++++++++++++++++
 tb/tb_frame_tick_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tick_rx.sv
// frame_tick_rx: brings a slow free-running frame clock (e.g. ~60 Hz vsync) into the clk domain,
//   strobes once per rising edge, measures the edge-to-edge period and tracks lock/loss.
// Latency: outputs for an edge are visible after clk edge k+2, where k first samples tick_in=1.
// Backpressure: none; strobes are unconditional single-cycle pulses, consumers must sample them.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   tick_in       asynchronous slow frame clock
//   frame_pulse   one-cycle strobe per detected rising edge
//   frame_cnt     detected-edge count, wraps at 16 bits
//   period        last measured edge-to-edge interval in clk cycles
//   period_valid  one-cycle strobe when period updates
//   locked        input stable within tolerance for LOCK_COUNT consecutive periods
//   lost          sticky timeout flag, cleared by the next detected edge
module frame_tick_rx #(
  parameter int unsigned NOMINAL    = 1666666,
  parameter int unsigned TOL        = 16384,
  parameter int unsigned TIMEOUT    = 2000000,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  output logic        frame_pulse,
  output logic [15:0] frame_cnt,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        lost
);

  localparam int unsigned       GOOD_W    = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [31:0]       CYC_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0]       CYC_SAT   = 32'(TIMEOUT);
  localparam logic [33:0]       NOM_W     = 34'(NOMINAL);
  localparam logic [33:0]       TOL_W     = 34'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOCKED
  } state_t;

  // Synchroniser, history and arming flops
  logic s0_q, s1_q, h_q;
  logic fill_q;
  logic armed_q, armed_d;

  // Measurement / FSM state
  state_t              state_q, state_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
  logic [31:0]         cyc_cnt_q, cyc_cnt_d;

  // Registered outputs
  logic                frame_pulse_q, frame_pulse_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [31:0]         period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;

  logic                rise_det;
  logic [31:0]         meas;
  logic [33:0]         meas_w;
  logic                in_tol;

  always_comb begin
    // The synchroniser resets to 0, so a tick_in already high at reset release would look
    // like a rise. Edges are only accepted once a genuine low has been sampled; fill_q marks
    // that s0_q holds a real sample rather than its reset value.
    armed_d  = armed_q | (fill_q & ~s0_q);
    rise_det = s1_q & ~h_q & armed_q;

    meas   = cyc_cnt_q + 32'd1;
    meas_w = {2'b00, meas};
    // |meas - NOMINAL| <= TOL as two ordered compares in a wider width, so nothing wraps.
    in_tol = ((meas_w + TOL_W) >= NOM_W) && (meas_w <= (NOM_W + TOL_W));

    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    frame_pulse_d  = 1'b0;
    period_valid_d = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    period_d       = period_q;
    lost_d         = lost_q;

    if (rise_det) begin
      cyc_cnt_d = 32'd0;
    end else if (cyc_cnt_q == CYC_SAT) begin
      cyc_cnt_d = cyc_cnt_q;
    end else begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end

    if (rise_det) begin
      frame_pulse_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + 16'd1;
      lost_d        = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // First edge only starts the measurement; there is no prior edge to measure from.
          state_d    = ST_MEASURE;
          good_cnt_d = '0;
        end
        ST_MEASURE: begin
          period_d       = meas;
          period_valid_d = 1'b1;
          if (in_tol) begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
            if ((good_cnt_q + GOOD_W'(1)) == GOOD_LOCK) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          period_d       = meas;
          period_valid_d = 1'b1;
          if (!in_tol) begin
            state_d    = ST_MEASURE;
            good_cnt_d = '0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          good_cnt_d = '0;
        end
      endcase
    end else if ((state_q != ST_IDLE) && (cyc_cnt_q == CYC_LAST)) begin
      // An edge in the same cycle takes the branch above, so it always beats the timeout.
      state_d    = ST_IDLE;
      lost_d     = 1'b1;
      good_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      h_q            <= 1'b0;
      fill_q         <= 1'b0;
      armed_q        <= 1'b0;
      state_q        <= ST_IDLE;
      good_cnt_q     <= '0;
      cyc_cnt_q      <= 32'd0;
      frame_pulse_q  <= 1'b0;
      frame_cnt_q    <= 16'd0;
      period_q       <= 32'd0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      s0_q           <= tick_in;
      s1_q           <= s0_q;
      h_q            <= s1_q;
      fill_q         <= 1'b1;
      armed_q        <= armed_d;
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      cyc_cnt_q      <= cyc_cnt_d;
      frame_pulse_q  <= frame_pulse_d;
      frame_cnt_q    <= frame_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      lost_q         <= lost_d;
    end
  end

  assign frame_pulse  = frame_pulse_q;
  assign frame_cnt    = frame_cnt_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_frame_tick_rx.sv
// tb_frame_tick_rx: directed test of frame_tick_rx with shortened timing parameters.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_frame_tick_rx;

  localparam int unsigned NOM = 100;
  localparam int unsigned TLR = 4;
  localparam int unsigned TO  = 300;
  localparam int unsigned LC  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_in = 1'b0;
  logic        frame_pulse;
  logic [15:0] frame_cnt;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        lost;

  int n_pass  = 0;
  int n_total = 0;

  // Event record, sampled on the falling edge
  int   tcount      = 0;
  int   n_pulse     = 0;
  int   n_pv        = 0;
  int   last_pulse_t = 0;
  int   lost_rise_t = 0;
  int   wide_cnt    = 0;
  int   bad_align   = 0;
  logic prev_pulse  = 1'b0;
  logic prev_pv     = 1'b0;
  logic prev_locked = 1'b0;
  logic prev_lost   = 1'b0;

  frame_tick_rx #(
    .NOMINAL   (NOM),
    .TOL       (TLR),
    .TIMEOUT   (TO),
    .LOCK_COUNT(LC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .frame_pulse (frame_pulse),
    .frame_cnt   (frame_cnt),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tcount <= tcount + 1;

  always @(negedge clk) begin
    if (frame_pulse) begin
      n_pulse      = n_pulse + 1;
      last_pulse_t = tcount;
      if (prev_pulse) wide_cnt = wide_cnt + 1;
    end
    if (period_valid) begin
      n_pv = n_pv + 1;
      if (prev_pv) wide_cnt = wide_cnt + 1;
    end
    if (lost && !prev_lost) lost_rise_t = tcount;
    // locked may only change together with period_valid or a rising lost
    if (!rst && (locked != prev_locked) && !period_valid && !(lost && !prev_lost))
      bad_align = bad_align + 1;
    prev_pulse  = frame_pulse;
    prev_pv     = period_valid;
    prev_locked = locked;
    prev_lost   = lost;
  end

  // One rising edge followed by p-cycle period of tick_in (rise to next rise)
  task automatic drive_period(input int p);
    tick_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    tick_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic test_reset();
    int bp;
    rst     = 1'b1;
    tick_in = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({frame_pulse, period_valid, locked, lost} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {frame_pulse, period_valid, locked, lost});
    else n_pass++;
    n_total++;
    if (frame_cnt !== 16'd0 || period !== 32'd0)
      $display("FAIL reset_counts: frame_cnt=%0h period=%0d want 0/0", frame_cnt, period);
    else n_pass++;
    bp  = n_pulse;
    rst = 1'b0;
    repeat (50) @(negedge clk);
    n_total++;
    if (n_pulse - bp != 0)
      $display("FAIL reset_high_release_pulses: got %0d want 0", n_pulse - bp);
    else n_pass++;
    n_total++;
    if (frame_cnt !== 16'd0)
      $display("FAIL reset_high_release_cnt: got %0h want 0", frame_cnt);
    else n_pass++;
    n_total++;
    if ({period_valid, locked, lost} !== 3'b000 || period !== 32'd0)
      $display("FAIL reset_high_release_outs: pv/lk/lost=%b period=%0d want 000/0",
               {period_valid, locked, lost}, period);
    else n_pass++;
  endtask

  task automatic test_lock();
    int bv;
    int t0;
    tick_in = 1'b0;
    repeat (10) @(negedge clk);
    bv = n_pv;
    for (int i = 0; i < 8; i++) begin
      t0 = tcount;
      drive_period(100);
      n_total++;
      if (last_pulse_t != t0 + 3)
        $display("FAIL lock_pulse_latency[%0d]: got %0d want %0d", i, last_pulse_t - t0, 3);
      else n_pass++;
      n_total++;
      if (n_pv - bv != i)
        $display("FAIL lock_pv_count[%0d]: got %0d want %0d", i, n_pv - bv, i);
      else n_pass++;
      n_total++;
      if (locked !== (i >= 3))
        $display("FAIL lock_state[%0d]: got %b want %b", i, locked, (i >= 3));
      else n_pass++;
    end
    n_total++;
    if (frame_cnt !== 16'd8)
      $display("FAIL lock_frame_cnt: got %0d want 8", frame_cnt);
    else n_pass++;
    n_total++;
    if (period !== 32'd100)
      $display("FAIL lock_period: got %0d want 100", period);
    else n_pass++;
  endtask

  task automatic test_bad_period();
    drive_period(110);
    n_total++;
    if (locked !== 1'b1)
      $display("FAIL bad_pre_locked: got %b want 1", locked);
    else n_pass++;
    drive_period(100);
    n_total++;
    if (period !== 32'd110)
      $display("FAIL bad_period_value: got %0d want 110", period);
    else n_pass++;
    n_total++;
    if (locked !== 1'b0)
      $display("FAIL bad_unlock: got %b want 0", locked);
    else n_pass++;
    for (int j = 0; j < 3; j++) begin
      drive_period(100);
      n_total++;
      if (locked !== (j == 2))
        $display("FAIL bad_relock[%0d]: got %b want %b", j, locked, (j == 2));
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int          bv;
    int          t0;
    logic [15:0] exp_fc;
    repeat (250) @(negedge clk);
    n_total++;
    if (lost !== 1'b1 || locked !== 1'b0)
      $display("FAIL timeout_flags: lost=%b locked=%b want 1/0", lost, locked);
    else n_pass++;
    n_total++;
    if (lost_rise_t - last_pulse_t != 300)
      $display("FAIL timeout_delay: got %0d want 300", lost_rise_t - last_pulse_t);
    else n_pass++;
    n_total++;
    if (period !== 32'd100)
      $display("FAIL timeout_period_kept: got %0d want 100", period);
    else n_pass++;
    bv      = n_pv;
    exp_fc  = frame_cnt + 16'd1;
    t0      = tcount;
    tick_in = 1'b1;
    repeat (5) @(negedge clk);
    n_total++;
    if (lost !== 1'b0)
      $display("FAIL timeout_lost_clear: got %b want 0", lost);
    else n_pass++;
    n_total++;
    if (frame_cnt !== exp_fc || last_pulse_t != t0 + 3)
      $display("FAIL timeout_recover_edge: cnt=%0d lat=%0d want %0d/3", frame_cnt, last_pulse_t - t0, exp_fc);
    else n_pass++;
    n_total++;
    if (n_pv != bv)
      $display("FAIL timeout_no_pv: got %0d want 0", n_pv - bv);
    else n_pass++;
    repeat (45) @(negedge clk);
    tick_in = 1'b0;
    repeat (50) @(negedge clk);
  endtask

  task automatic test_tolerance();
    int tp[11]      = '{96, 104, 95, 105, 100, 100, 95, 100, 100, 104, 100};
    int exp_per[11] = '{100, 96, 104, 95, 105, 100, 100, 95, 100, 100, 104};
    bit exp_lk[11]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int bv;
    for (int i = 0; i < 11; i++) begin
      bv = n_pv;
      drive_period(tp[i]);
      n_total++;
      if (n_pv - bv != 1 || period !== 32'(exp_per[i]))
        $display("FAIL tol_period[%0d]: pv=%0d period=%0d want 1/%0d", i, n_pv - bv, period, exp_per[i]);
      else n_pass++;
      n_total++;
      if (locked !== exp_lk[i])
        $display("FAIL tol_locked[%0d]: got %b want %b", i, locked, exp_lk[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    n_total++;
    if (frame_cnt !== 16'hFFFE)
      $display("FAIL wrap_preload: got %0h want fffe", frame_cnt);
    else n_pass++;
    drive_period(100);
    n_total++;
    if (frame_cnt !== 16'hFFFF)
      $display("FAIL wrap_ffff: got %0h want ffff", frame_cnt);
    else n_pass++;
    drive_period(100);
    n_total++;
    if (frame_cnt !== 16'h0000)
      $display("FAIL wrap_zero: got %0h want 0000", frame_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bp;
    int bv;
    tick_in = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if (frame_cnt !== 16'd1 || locked !== 1'b1)
      $display("FAIL mid_pre: cnt=%0d locked=%b want 1/1", frame_cnt, locked);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({frame_pulse, period_valid, locked, lost} !== 4'b0000 || frame_cnt !== 16'd0 || period !== 32'd0)
      $display("FAIL mid_async_reset: flags=%b cnt=%0d period=%0d want 0",
               {frame_pulse, period_valid, locked, lost}, frame_cnt, period);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    bp  = n_pulse;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_total++;
    if (n_pulse != bp)
      $display("FAIL mid_release_pulse: got %0d want 0", n_pulse - bp);
    else n_pass++;
    tick_in = 1'b0;
    repeat (10) @(negedge clk);
    bp = n_pulse;
    bv = n_pv;
    drive_period(100);
    n_total++;
    if (n_pulse - bp != 1 || n_pv != bv || frame_cnt !== 16'd1)
      $display("FAIL mid_idle_edge: pulses=%0d pv=%0d cnt=%0d want 1/0/1", n_pulse - bp, n_pv - bv, frame_cnt);
    else n_pass++;
    drive_period(100);
    n_total++;
    if (n_pv - bv != 1 || period !== 32'd100)
      $display("FAIL mid_measure: pv=%0d period=%0d want 1/100", n_pv - bv, period);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int bp;
    tick_in = 1'b0;
    repeat (10) @(negedge clk);
    bp      = n_pulse;
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    repeat (10) @(negedge clk);
    n_total++;
    if (n_pulse - bp > 1)
      $display("FAIL glitch_pulses: got %0d want <=1", n_pulse - bp);
    else n_pass++;
  endtask

  task automatic test_strobe_shape();
    n_total++;
    if (wide_cnt != 0)
      $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", wide_cnt);
    else n_pass++;
    n_total++;
    if (bad_align != 0)
      $display("FAIL locked_alignment: got %0d misaligned changes want 0", bad_align);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lock();
    test_bad_period();
    test_timeout();
    test_tolerance();
    test_wrap();
    test_reset_mid();
    test_glitch();
    test_strobe_shape();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
